skylark_mem_arbiter: RTL and testbench
======================================

# skylark_mem_arbiter

Sequences a single-ported unified memory between the skylark core's instruction-fetch requester and its data (load/store) requester. One access at a time: requests are arbitrated, the memory command is issued for one cycle, read data is captured after a fixed memory latency, and a completion pulse is returned to the owning requester. Also produces the fetch and memory stall levels that the core's hazard logic folds into its pipeline stall/flush decisions.

## Interface
- MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- STARVE_LIMIT, 4, max consecutive data grants while if_req is pending before fetch is forced; legal range 1..15
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_done
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word; valid while if_done=1, holds until next fetch capture
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; valid while d_done=1, holds until next data capture
- d_done  out  1  one-cycle data completion pulse (loads and stores)
- mem_en  out  1  memory command strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  32  memory address, passed through unmodified
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after mem_en
- stall_f  out  1  if_req & ~if_done
- stall_m  out  1  d_req & ~d_done
- busy  out  1  1 whenever state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: no request -> stay. Any request -> arbitrate, register owner, we, addr, wdata into mem_* outputs; -> ISSUE.
- Arbitration: data wins by default. Fetch wins if d_req=0, or if starve_cnt == STARVE_LIMIT and if_req=1.
- starve_cnt: +1 on data grant while if_req=1 (saturates at STARVE_LIMIT); cleared on fetch grant or on data grant with if_req=0.
- ISSUE: mem_en=1 for this cycle only; wait counter loaded MEM_LATENCY-1; -> WAIT.
- WAIT: counter decrements; at counter 0 capture mem_rdata into owner's rdata register (stores capture nothing); -> DONE.
- DONE: owner's done pulses; requests ignored this cycle; -> IDLE.
- mem_we/mem_addr/mem_wdata hold registered values from grant until next grant; meaningful only with mem_en.
- Requester dropping req mid-access: access still completes, done still pulses, requester ignores it.
- Only the owner's done/rdata change; the other port's rdata holds.

## Timing
- Grant in IDLE cycle T; mem_en in T+1; mem_rdata sampled in T+1+MEM_LATENCY; done pulse in T+2+MEM_LATENCY; next arbitration no earlier than T+3+MEM_LATENCY.
- Per-access occupancy: MEM_LATENCY+3 cycles; fetch and data never overlap.
- Requester sees done in cycle D, may change req/operands at edge D; new value sampled in IDLE at D+1.
- stall_f/stall_m are combinational from inputs and registered done; they fall in the done cycle.
- Reset (reset=0 at a rising edge): state IDLE, starve_cnt 0, counter 0, mem_en/mem_we 0, mem_addr/mem_wdata 0, if_rdata/d_rdata 0, if_done/d_done 0, busy 0. Applies mid-access: access aborted, no done pulse, an already-issued store is not retracted.
- Simultaneous if_req and d_req in IDLE: exactly one grant per the arbitration rule; loser keeps stall asserted.

## Test plan
- Reset: hold reset=0 two cycles with both reqs high -> all outputs 0, busy=0, no mem_en.
- Single load, MEM_LATENCY=2: d_req=1, d_we=0, d_addr=0x100 at T, memory returns 0xDEADBEEF -> mem_en=1/mem_addr=0x100 at T+1, d_done=1 with d_rdata=0xDEADBEEF at T+4, stall_m low at T+4.
- Store: d_we=1, d_addr=0x20, d_wdata=0x12345678 -> single mem_en cycle with mem_we=1, mem_wdata=0x12345678; d_done at T+4; if_rdata unchanged.
- Contention: if_req and d_req both high at T -> data granted first; fetch mem_en issued at T+6 (grant T+5).
- Starvation, STARVE_LIMIT=4: if_req held, d_req re-asserted continuously -> 4 data accesses, then fetch granted, then data resumes.
- Reset mid-access: reset=0 during WAIT -> no done pulse, busy=0 next cycle, subsequent fetch to 0x0 completes normally.

Source files
------------

// File: rtl/skylark_mem_arbiter.sv
// Arbitrates the skylark core's fetch and load/store requesters onto one
// single-ported memory, one access at a time, with a fixed read latency.
module skylark_mem_arbiter #(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall_f,
   output logic        stall_m,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   state_t     state, state_next;
   logic [3:0] starve_cnt;
   logic [3:0] wait_cnt;
   logic       owner_data;
   logic       grant_fetch;
   logic       grant_data;
   logic       capture;

   always_comb begin
      state_next  = state;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      capture     = 1'b0;
      case (state)
         IDLE: begin
            // Data has priority unless fetch has been passed over LIMIT times.
            grant_fetch = if_req && (!d_req || starve_cnt == LIMIT);
            grant_data  = d_req && !grant_fetch;
            if (grant_fetch || grant_data) state_next = ISSUE;
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               capture    = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_cnt <= 4'd0;
         wait_cnt   <= 4'd0;
         owner_data <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         if_rdata   <= 32'd0;
         d_rdata    <= 32'd0;
         if_done    <= 1'b0;
         d_done     <= 1'b0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         if (grant_fetch || grant_data) begin
            owner_data <= grant_data;
            mem_we     <= grant_data && d_we;
            mem_addr   <= grant_data ? d_addr : if_addr;
            mem_wdata  <= d_wdata;
            if (grant_data && if_req) begin
               if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
            end else begin
               starve_cnt <= 4'd0;
            end
         end
         if (state == ISSUE)                        wait_cnt <= LAT_M1;
         else if (state == WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
         // Stores complete without touching either read-data register.
         if (capture) begin
            if (owner_data) begin
               d_done <= 1'b1;
               if (!mem_we) d_rdata <= mem_rdata;
            end else begin
               if_done  <= 1'b1;
               if_rdata <= mem_rdata;
            end
         end
      end
   end

   assign mem_en  = (state == ISSUE);
   assign busy    = (state != IDLE);
   assign stall_f = if_req & ~if_done;
   assign stall_m = d_req & ~d_done;

endmodule

// File: tb/tb_skylark_mem_arbiter.sv
// Directed self-checking bench for skylark_mem_arbiter with a small
// fixed-latency memory model behind it.
module tb_skylark_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_f;
   logic        stall_m;
   logic        busy;

   int vec_count  = 0;
   int miss_count = 0;
   int en_count   = 0;

   logic [31:0] mem [0:255];
   logic        rd_v1 = 1'b0, rd_v2 = 1'b0;
   logic [31:0] rd_d1 = 32'd0, rd_d2 = 32'd0;

   always #5 clk = ~clk;

   skylark_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall_f(stall_f), .stall_m(stall_m), .busy(busy)
   );

   // Two-cycle read pipeline; outside the valid slot the bus carries junk.
   always @(posedge clk) begin
      rd_v1 <= mem_en && !mem_we;
      rd_d1 <= mem[mem_addr[9:2]];
      rd_v2 <= rd_v1;
      rd_d2 <= rd_d1;
      if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_en) en_count <= en_count + 1;
   end
   assign mem_rdata = rd_v2 ? rd_d2 : 32'h0BAD_0BAD;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vec_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic we,
                                input logic [31:0] daddr, input logic [31:0] wdata);
      if_req  = ireq;
      if_addr = iaddr;
      d_req   = dreq;
      d_we    = we;
      d_addr  = daddr;
      d_wdata = wdata;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [31:0] exp_addr [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h0, 32'h100};
   int en_snap;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[0]  = 32'hCAFE_0000;
      mem[64] = 32'hDEAD_BEEF;

      // Reset held two cycles with both requests up
      reset = 1'b0;
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0);
      for (int c = 0; c < 2; c++) begin
         waitCycles(1);
         checkOutput("rst_busy", {31'd0, busy}, 32'd0);
         checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
         checkOutput("rst_dones", {30'd0, if_done, d_done}, 32'd0);
         checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
      end
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      checkOutput("rst_if_rdata", if_rdata, 32'd0);
      checkOutput("rst_d_rdata", d_rdata, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      waitCycles(1);

      // Single load from 0x100
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
      checkOutput("ld_idle_busy", {31'd0, busy}, 32'd0);
      waitCycles(1);
      checkOutput("ld_mem_en", {31'd0, mem_en}, 32'd1);
      checkOutput("ld_mem_addr", mem_addr, 32'h100);
      checkOutput("ld_mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("ld_stall_m", {31'd0, stall_m}, 32'd1);
      waitCycles(1);
      checkOutput("ld_mem_en_once", {31'd0, mem_en}, 32'd0);
      waitCycles(1);
      checkOutput("ld_done_early", {31'd0, d_done}, 32'd0);
      waitCycles(1);
      checkOutput("ld_done", {31'd0, d_done}, 32'd1);
      checkOutput("ld_rdata", d_rdata, 32'hDEAD_BEEF);
      checkOutput("ld_stall_m_low", {31'd0, stall_m}, 32'd0);
      checkOutput("ld_if_done", {31'd0, if_done}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      waitCycles(1);
      checkOutput("ld_done_pulse", {31'd0, d_done}, 32'd0);
      checkOutput("ld_busy_after", {31'd0, busy}, 32'd0);
      checkOutput("ld_rdata_hold", d_rdata, 32'hDEAD_BEEF);

      // Store of 0x12345678 to 0x20
      en_snap = en_count;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
      waitCycles(1);
      checkOutput("st_mem_en", {31'd0, mem_en}, 32'd1);
      checkOutput("st_mem_we", {31'd0, mem_we}, 32'd1);
      checkOutput("st_mem_addr", mem_addr, 32'h20);
      checkOutput("st_mem_wdata", mem_wdata, 32'h1234_5678);
      waitCycles(3);
      checkOutput("st_done", {31'd0, d_done}, 32'd1);
      checkOutput("st_if_rdata", if_rdata, 32'd0);
      checkOutput("st_d_rdata_hold", d_rdata, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      waitCycles(1);
      checkOutput("st_en_count", 32'(en_count - en_snap), 32'd1);
      checkOutput("st_mem_word", mem[8], 32'h1234_5678);

      // Contention: data first, fetch granted five cycles later
      applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h100, 32'h0);
      waitCycles(1);
      checkOutput("ct_first_addr", mem_addr, 32'h100);
      checkOutput("ct_stall_f", {31'd0, stall_f}, 32'd1);
      waitCycles(3);
      checkOutput("ct_d_done", {31'd0, d_done}, 32'd1);
      checkOutput("ct_if_done_lo", {31'd0, if_done}, 32'd0);
      checkOutput("ct_stall_f_hold", {31'd0, stall_f}, 32'd1);
      d_req = 1'b0;
      waitCycles(1);
      checkOutput("ct_idle_gap", {30'd0, busy, mem_en}, 32'd0);
      waitCycles(1);
      checkOutput("ct_fetch_en", {31'd0, mem_en}, 32'd1);
      checkOutput("ct_fetch_addr", mem_addr, 32'h20);
      waitCycles(3);
      checkOutput("ct_if_done", {31'd0, if_done}, 32'd1);
      checkOutput("ct_if_rdata", if_rdata, 32'h1234_5678);
      checkOutput("ct_stall_f_low", {31'd0, stall_f}, 32'd0);
      checkOutput("ct_d_rdata_hold", d_rdata, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      waitCycles(1);

      // Starvation: four data grants, then fetch, then data again
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
      for (int a = 0; a < 6; a++) begin
         waitCycles(1);
         checkOutput($sformatf("sv_addr%0d", a), mem_addr, exp_addr[a]);
         checkOutput($sformatf("sv_en%0d", a), {31'd0, mem_en}, 32'd1);
         waitCycles(3);
         checkOutput($sformatf("sv_done%0d", a), {30'd0, if_done, d_done},
                     (a == 4) ? 32'd2 : 32'd1);
         if (a == 5) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
         waitCycles(1);
      end
      checkOutput("sv_if_rdata", if_rdata, 32'hCAFE_0000);

      // Reset during WAIT aborts the load; a later fetch runs normally
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
      waitCycles(2);
      checkOutput("ra_in_wait", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      waitCycles(1);
      checkOutput("ra_busy", {31'd0, busy}, 32'd0);
      checkOutput("ra_d_rdata", d_rdata, 32'd0);
      reset = 1'b1;
      d_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checkOutput("ra_no_done", {30'd0, if_done, d_done}, 32'd0);
         waitCycles(1);
      end
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      waitCycles(1);
      checkOutput("ra_f_en", {31'd0, mem_en}, 32'd1);
      checkOutput("ra_f_addr", mem_addr, 32'h0);
      waitCycles(3);
      checkOutput("ra_f_done", {31'd0, if_done}, 32'd1);
      checkOutput("ra_f_rdata", if_rdata, 32'hCAFE_0000);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      waitCycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
